// File: rtl/adaptive_filter_stream_source.sv
// Buffered sample source for the adaptive_filter input stream. Plays back a loaded
// buffer once or in a loop, with a programmable gap between valid samples.
module adaptive_filter_stream_source #(
  parameter int unsigned WORDLENGTH     = 14,
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned RATE_DIV_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WORDLENGTH-1:0]     wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [$clog2(DEPTH):0]    num_samples,
  input  logic [RATE_DIV_WIDTH-1:0] rate_div,
  output logic [WORDLENGTH-1:0]     m_tdata,
  output logic                      m_tvalid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne = CW'(1);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e                    state_q;
  logic [WORDLENGTH-1:0]     mem [DEPTH];
  logic [AW-1:0]             ptr_q;
  logic [RATE_DIV_WIDTH-1:0] cnt_q;
  logic [RATE_DIV_WIDTH-1:0] rate_q;
  logic [CW-1:0]             n_q;
  logic                      loop_q;
  logic                      fin_q;      // one-shot pass has issued its final read
  logic                      rd_pend_q;
  logic                      rd_last_q;
  logic                      m_last_q;
  logic [WORDLENGTH-1:0]     rd_data_q;

  logic [CW-1:0] num_clamped;
  logic          last_idx;
  logic          flush;

  assign num_clamped = (num_samples > DepthC) ? DepthC : num_samples;
  assign last_idx    = ({1'b0, ptr_q} == (n_q - CntOne));
  assign flush       = (state_q == StPlay) && stop;

  // Non-blocking write alongside the read below gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rate_q    <= '0;
      n_q       <= '0;
      loop_q    <= 1'b0;
      fin_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_data_q <= '0;
      m_last_q  <= 1'b0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      m_tvalid  <= rd_pend_q && !flush;
      m_last_q  <= rd_last_q && !flush;
      if (rd_pend_q && !flush) begin
        m_tdata <= rd_data_q;
      end

      unique case (state_q)
        StIdle: begin
          if (start && !stop && (num_samples != '0)) begin
            state_q <= StPlay;
            busy    <= 1'b1;
            n_q     <= num_clamped;
            loop_q  <= loop_en;
            rate_q  <= rate_div;
            ptr_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
          end
        end
        StPlay: begin
          if (stop) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (m_last_q) begin
            // Final sample of a one-shot pass was on the bus last cycle.
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (!fin_q) begin
            if (cnt_q == '0) begin
              rd_pend_q <= 1'b1;
              rd_data_q <= mem[ptr_q];
              cnt_q     <= rate_q;
              if (last_idx) begin
                ptr_q <= '0;
                if (!loop_q) begin
                  fin_q     <= 1'b1;
                  rd_last_q <= 1'b1;
                end
              end else begin
                ptr_q <= ptr_q + AW'(1);
              end
            end else begin
              cnt_q <= cnt_q - RATE_DIV_WIDTH'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_filter_stream_source.sv
// Directed bench for adaptive_filter_stream_source: one-shot, rate-divided, looped,
// clamped, live-rewrite and reset-abort playback against hand-computed sequences.
module tb_adaptive_filter_stream_source;

  localparam int unsigned WL    = 14;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned RW    = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk;
  logic          srst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WL-1:0] wr_data;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [AW:0]   num_samples;
  logic [RW-1:0] rate_div;
  logic [WL-1:0] m_tdata;
  logic          m_tvalid;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  adaptive_filter_stream_source #(
    .WORDLENGTH    (WL),
    .DEPTH         (DEPTH),
    .RATE_DIV_WIDTH(RW)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .num_samples(num_samples),
    .rate_div   (rate_div),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic buf_write(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = WL'(data);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic kick(input int n, input int rate, input logic lp);
    num_samples = (AW + 1)'(n);
    rate_div    = RW'(rate);
    loop_en     = lp;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  initial begin
    logic [WL-1:0] t5_exp [8];
    logic [WL-1:0] t6_exp [4];
    t5_exp = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd0, 14'd1, 14'h1ABC, 14'd3};
    t6_exp = '{14'd0, 14'd1, 14'h1ABC, 14'd3};

    srst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_samples = '0; rate_div = '0;
    step();
    step();
    check_eq("rst_valid", 32'(m_tvalid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_data", 32'(m_tdata), 0);
    srst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) buf_write(i, i);

    // 1: one-shot, back-to-back samples
    kick(8, 0, 1'b0);
    check_eq("t1_busy_start", 32'(busy), 1);
    check_eq("t1_lat0", 32'(m_tvalid), 0);
    step();
    check_eq("t1_lat1", 32'(m_tvalid), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("t1_valid", 32'(m_tvalid), 1);
      check_eq("t1_data", 32'(m_tdata), 32'(i));
      check_eq("t1_nodone", 32'(done), 0);
    end
    step();
    check_eq("t1_done", 32'(done), 1);
    check_eq("t1_valid_end", 32'(m_tvalid), 0);
    check_eq("t1_busy_end", 32'(busy), 0);
    step();
    check_eq("t1_done_pulse", 32'(done), 0);

    // 2: rate_div=2 gives one valid every third cycle, data held in the gaps
    kick(8, 2, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("t2_valid", 32'(m_tvalid), 1);
      check_eq("t2_data", 32'(m_tdata), 32'(i));
      if (i < 7) begin
        for (int k = 0; k < 2; k++) begin
          step();
          check_eq("t2_gap", 32'(m_tvalid), 0);
          check_eq("t2_hold", 32'(m_tdata), 32'(i));
        end
      end
    end
    step();
    check_eq("t2_done", 32'(done), 1);
    check_eq("t2_busy_end", 32'(busy), 0);

    // 3: looped four-sample pass, stop after ten valids
    kick(4, 0, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t3_valid", 32'(m_tvalid), 1);
      check_eq("t3_data", 32'(m_tdata), 32'(i % 4));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("t3_stop_valid", 32'(m_tvalid), 0);
    check_eq("t3_stop_busy", 32'(busy), 0);
    check_eq("t3_stop_hold", 32'(m_tdata), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t3_quiet_valid", 32'(m_tvalid), 0);
      check_eq("t3_quiet_done", 32'(done), 0);
    end

    // 4a: zero-length start and start+stop are ignored
    kick(0, 0, 1'b0);
    check_eq("t4_zero_busy", 32'(busy), 0);
    step();
    check_eq("t4_zero_valid", 32'(m_tvalid), 0);
    stop = 1'b1;
    kick(4, 0, 1'b0);
    stop = 1'b0;
    check_eq("t4_startstop_busy", 32'(busy), 0);
    step();
    check_eq("t4_startstop_valid", 32'(m_tvalid), 0);

    // 4b: oversize count clamps to the buffer depth
    for (int i = 0; i < int'(DEPTH); i++) buf_write(i, i);
    kick(200, 0, 1'b0);
    step();
    for (int i = 0; i < int'(DEPTH); i++) begin
      step();
      check_eq("t4_valid", 32'(m_tvalid), 1);
      check_eq("t4_data", 32'(m_tdata), 32'(i));
    end
    step();
    check_eq("t4_done", 32'(done), 1);
    check_eq("t4_valid_end", 32'(m_tvalid), 0);

    // 5: rewrite index 2 on the very edge it is read: old data now, new data next pass
    kick(4, 0, 1'b1);
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t5_valid", 32'(m_tvalid), 1);
      check_eq("t5_data", 32'(m_tdata), 32'(t5_exp[k]));
      if (k == 0) begin
        wr_en = 1'b1; wr_addr = AW'(2); wr_data = 14'h1ABC;
      end else begin
        wr_en = 1'b0;
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("t5_stop_valid", 32'(m_tvalid), 0);

    // 6: reset mid-playback, then replay with buffer intact
    kick(4, 0, 1'b0);
    step();
    step();
    step();
    check_eq("t6_pre_data", 32'(m_tdata), 1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_eq("t6_rst_valid", 32'(m_tvalid), 0);
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_done", 32'(done), 0);
    check_eq("t6_rst_data", 32'(m_tdata), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t6_quiet", 32'(m_tvalid), 0);
    end
    kick(4, 0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t6_valid", 32'(m_tvalid), 1);
      check_eq("t6_data", 32'(m_tdata), 32'(t6_exp[k]));
    end
    step();
    check_eq("t6_done", 32'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
